mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences every access through a small FSM and returns a registered acknowledge with read data.
- Drives the stall signals that freeze PC, IF/ID and downstream pipeline registers while an access is outstanding.
- Sits between the PC/IF/ID logic, the EX/MEM register and the external memory model.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch (I)
// and load/store (D) ports, with a timeout abort and pipeline stall outputs.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            if_stall,
  output logic            mem_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            err
);

  localparam int BW = DW / 8;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arbState;

  arbState         stateReg;
  arbState         stateNext;
  logic            lastGrantD;
  logic            grantDReg;
  logic [AW-1:0]   addrReg;
  logic            weReg;
  logic [DW-1:0]   wdataReg;
  logic [BW-1:0]   beReg;
  logic [DW-1:0]   iRdataReg;
  logic [DW-1:0]   dRdataReg;
  logic [7:0]      cntReg;
  logic            errReg;

  logic            anyReq;
  logic            pickD;
  logic            timeoutHit;

  assign anyReq     = i_req | d_req;
  // Contention goes to whichever port did not win last time.
  assign pickD      = d_req & (~i_req | ~lastGrantD);
  assign timeoutHit = (cntReg == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (anyReq) stateNext = ACCESS;
      ACCESS:  if (mem_ready || timeoutHit) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    case (stateReg)
      ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = weReg;
        mem_addr  = addrReg;
        mem_wdata = wdataReg;
        mem_be    = beReg;
      end
      RESP: begin
        i_ack = ~grantDReg;
        d_ack = grantDReg;
      end
      default: ;
    endcase
  end

  // Request attributes are frozen at grant; inputs are ignored until IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGrantD <= 1'b0;
      grantDReg  <= 1'b0;
      addrReg    <= '0;
      weReg      <= 1'b0;
      wdataReg   <= '0;
      beReg      <= '0;
    end else if (stateReg == IDLE && anyReq) begin
      lastGrantD <= pickD;
      grantDReg  <= pickD;
      addrReg    <= pickD ? d_addr : i_addr;
      weReg      <= pickD & d_we;
      wdataReg   <= pickD ? d_wdata : '0;
      beReg      <= pickD ? d_be : '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iRdataReg <= '0;
      dRdataReg <= '0;
      cntReg    <= '0;
      errReg    <= 1'b0;
    end else if (stateReg == ACCESS) begin
      if (mem_ready) begin
        cntReg <= '0;
        if (grantDReg) begin
          dRdataReg <= weReg ? '0 : mem_rdata;
        end else begin
          iRdataReg <= mem_rdata;
        end
      end else if (timeoutHit) begin
        // Abort: return zero data and remember the failure until reset.
        cntReg <= '0;
        errReg <= 1'b1;
        if (grantDReg) begin
          dRdataReg <= '0;
        end else begin
          iRdataReg <= '0;
        end
      end else begin
        cntReg <= cntReg + 8'd1;
      end
    end
  end

  assign i_rdata   = iRdataReg;
  assign d_rdata   = dRdataReg;
  assign err       = errReg;
  assign if_stall  = i_req & ~i_ack;
  assign mem_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, waited store, contention,
// timeout abort and asynchronous reset during an access.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        if_stall;
  logic        mem_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        err;

  logic        autoMem = 1'b0;
  logic        memReadyMan = 1'b0;
  logic [31:0] memRdataMan = '0;
  int          checks = 0;
  int          errors = 0;

  // Auto mode: zero-wait memory whose read data is {addr[15:0], 16'hBEEF}.
  assign mem_ready = autoMem ? 1'b1 : memReadyMan;
  assign mem_rdata = autoMem ? {mem_addr[15:0], 16'hBEEF} : memRdataMan;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_ack(d_ack), .d_rdata(d_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    autoMem = 1'b0;
    memReadyMan = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    doReset();
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_i_ack", 32'(i_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);

    // Single fetch
    nextCycle();
    i_req = 1'b1; i_addr = 32'h0000_3000;
    #1;
    chk("f_stall_c1", 32'(if_stall), 32'd1);
    chk("f_memreq_c1", 32'(mem_req), 32'd0);
    nextCycle();
    memReadyMan = 1'b1; memRdataMan = 32'h2008_0005;
    #1;
    chk("f_memreq_c2", 32'(mem_req), 32'd1);
    chk("f_addr_c2", mem_addr, 32'h0000_3000);
    chk("f_we_c2", 32'(mem_we), 32'd0);
    chk("f_be_c2", 32'(mem_be), 32'hF);
    chk("f_stall_c2", 32'(if_stall), 32'd1);
    nextCycle();
    memReadyMan = 1'b0;
    #1;
    chk("f_iack_c3", 32'(i_ack), 32'd1);
    chk("f_rdata_c3", i_rdata, 32'h2008_0005);
    chk("f_stall_c3", 32'(if_stall), 32'd0);
    chk("f_memreq_c3", 32'(mem_req), 32'd0);
    i_req = 1'b0;
    nextCycle();
    #1;
    chk("f_iack_c4", 32'(i_ack), 32'd0);

    // Byte store with three wait states
    nextCycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hAABB_CCDD; d_be = 4'b0010;
    #1;
    chk("s_mstall", 32'(mem_stall), 32'd1);
    for (int w = 0; w < 4; w++) begin
      nextCycle();
      memReadyMan = (w == 3);
      #1;
      chk("s_memreq", 32'(mem_req), 32'd1);
      chk("s_addr", mem_addr, 32'h10);
      chk("s_wdata", mem_wdata, 32'hAABB_CCDD);
      chk("s_be", 32'(mem_be), 32'h2);
      chk("s_we", 32'(mem_we), 32'd1);
      chk("s_dack_early", 32'(d_ack), 32'd0);
    end
    nextCycle();
    memReadyMan = 1'b0;
    #1;
    chk("s_dack", 32'(d_ack), 32'd1);
    chk("s_drdata", d_rdata, 32'd0);
    chk("s_memreq_off", 32'(mem_req), 32'd0);
    chk("s_err", 32'(err), 32'd0);
    chk("s_mstall_off", 32'(mem_stall), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    nextCycle();
    #1;
    chk("s_dack_once", 32'(d_ack), 32'd0);

    // Simultaneous requests after reset: D, I, D, I
    doReset();
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_addr = 32'h200; d_we = 1'b0; d_be = 4'hF;
    autoMem = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) nextCycle();
      #1;
      chk("c_dack", 32'(d_ack), 32'((k % 6) == 2));
      chk("c_iack", 32'(i_ack), 32'((k % 6) == 5));
      if ((k % 6) == 1) chk("c_addr_d", mem_addr, 32'h200);
      if ((k % 6) == 4) chk("c_addr_i", mem_addr, 32'h100);
      if ((k % 6) == 2) chk("c_drdata", d_rdata, 32'h0200_BEEF);
      if ((k % 6) == 5) chk("c_irdata", i_rdata, 32'h0100_BEEF);
    end
    i_req = 1'b0; d_req = 1'b0; autoMem = 1'b0;

    // Timeout on a load (TIMEOUT=4)
    nextCycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; memReadyMan = 1'b0;
    for (int w = 0; w < 4; w++) begin
      nextCycle();
      #1;
      chk("t_memreq", 32'(mem_req), 32'd1);
      chk("t_dack_early", 32'(d_ack), 32'd0);
      chk("t_err_early", 32'(err), 32'd0);
    end
    nextCycle();
    #1;
    chk("t_dack", 32'(d_ack), 32'd1);
    chk("t_drdata", d_rdata, 32'd0);
    chk("t_err", 32'(err), 32'd1);
    d_req = 1'b0;
    nextCycle();
    i_req = 1'b1; i_addr = 32'h44;
    nextCycle();
    memReadyMan = 1'b1; memRdataMan = 32'h1234_ABCD;
    #1;
    chk("t2_memreq", 32'(mem_req), 32'd1);
    nextCycle();
    memReadyMan = 1'b0;
    #1;
    chk("t2_iack", 32'(i_ack), 32'd1);
    chk("t2_irdata", i_rdata, 32'h1234_ABCD);
    chk("t2_err_sticky", 32'(err), 32'd1);
    i_req = 1'b0;

    // Reset asserted mid-access
    nextCycle();
    i_req = 1'b1; i_addr = 32'h80;
    nextCycle();
    #1;
    chk("r_memreq_pre", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("r_memreq", 32'(mem_req), 32'd0);
    chk("r_iack", 32'(i_ack), 32'd0);
    chk("r_dack", 32'(d_ack), 32'd0);
    chk("r_err", 32'(err), 32'd0);
    i_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_addr = 32'h90; d_we = 1'b0;
    #1;
    chk("r_idle", 32'(mem_req), 32'd0);
    nextCycle();
    memReadyMan = 1'b1; memRdataMan = 32'hCAFE_F00D;
    #1;
    chk("r_grant_d", mem_addr, 32'h90);
    chk("r_memreq2", 32'(mem_req), 32'd1);
    nextCycle();
    memReadyMan = 1'b0;
    #1;
    chk("r_dack2", 32'(d_ack), 32'd1);
    chk("r_iack2", 32'(i_ack), 32'd0);
    chk("r_drdata2", d_rdata, 32'hCAFE_F00D);
    i_req = 1'b0; d_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
